// File: rtl/pwm_spi_cfg_ctrl.sv
// SPI-slave (mode 0) configuration controller for the PWM peripheral's five control registers.
// Optional macro SPI_READBACK_EN: read frames shift the addressed register out on cipo_o.
module pwm_spi_cfg_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_i,
    input  logic       copi_i,
    input  logic       ncs_i,
    output logic       cipo_o,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        OVERRUN = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_DONE = 3'(SYNC_STAGES + 1);

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
    logic sclk_dly_q, sclk_dly_d;
    logic ncs_dly_q, ncs_dly_d;
    logic [2:0] flush_q, flush_d;
    logic armed_q, armed_d;

    logic [15:0] shift_q, shift_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic        frame_err_q, frame_err_d;
    logic        cipo_q, cipo_d;
    logic [NUM_REGS-1:0][7:0] regs_q, regs_d;

    logic sclk_s, copi_s, ncs_s;
    logic sclk_rise, ncs_fall, ncs_rise;
    logic commit;
    logic addr_ok;

    assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
    assign copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi_i};
    assign ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs_i};

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];

    assign sclk_dly_d = sclk_s;
    assign ncs_dly_d  = ncs_s;

    // A chip-select fall only counts once the chain has flushed after reset and ncs has been seen high.
    assign flush_d  = (flush_q == FLUSH_DONE) ? flush_q : flush_q + 3'd1;
    assign armed_d  = armed_q | ((flush_q == FLUSH_DONE) & ncs_s & ncs_dly_q);

    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign ncs_fall  = ~ncs_s & ncs_dly_q & armed_q;
    assign ncs_rise  = ncs_s & ~ncs_dly_q;

    assign addr_ok = (int'(shift_q[14:8]) < NUM_REGS);

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        wr_strobe_d = 1'b0;
        frame_err_d = 1'b0;
        commit      = 1'b0;
        case (state_q)
            IDLE: begin
                if (ncs_fall) begin
                    state_d = SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_d = IDLE;
                    if (cnt_q == 5'd16) begin
                        commit = shift_q[15] & addr_ok;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (sclk_rise) begin
                    if (cnt_q == 5'd16) begin
                        state_d = OVERRUN;
                    end else begin
                        shift_d = {shift_q[14:0], copi_s};
                        cnt_d   = cnt_q + 5'd1;
                    end
                end
            end
            OVERRUN: begin
                if (ncs_rise) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        wr_strobe_d = commit;
    end

    // Whole-byte update of the addressed register in the commit cycle only.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign regs_d[gi] = (commit && (shift_q[14:8] == 7'(gi))) ? shift_q[7:0] : regs_q[gi];
        end
    endgenerate

`ifdef SPI_READBACK_EN
    logic [7:0] rb_q, rb_d;
    logic [2:0] rb_left_q, rb_left_d;
    logic       rb_act_q, rb_act_d;
    logic       sclk_fall;
    logic [6:0] rd_addr;
    logic [7:0] rd_val;

    assign sclk_fall = ~sclk_s & sclk_dly_q;
    // Address is complete on the 8th rise: seven bits already shifted plus the incoming one.
    assign rd_addr   = {shift_q[5:0], copi_s};

    always_comb begin
        rd_val = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == 7'(i)) begin
                rd_val = regs_q[i];
            end
        end
    end

    always_comb begin
        rb_d      = rb_q;
        rb_left_d = rb_left_q;
        rb_act_d  = rb_act_q;
        if ((state_q != SHIFT) || ncs_rise) begin
            rb_act_d = 1'b0;
        end else if (sclk_rise && (cnt_q == 5'd7) && !shift_q[6]) begin
            rb_d      = rd_val;
            rb_left_d = 3'd7;
            rb_act_d  = 1'b1;
        end else if (sclk_fall && rb_act_q) begin
            if (rb_left_q != 3'd0) begin
                rb_d      = {rb_q[6:0], 1'b0};
                rb_left_d = rb_left_q - 3'd1;
            end else begin
                rb_act_d = 1'b0;
            end
        end
        cipo_d = rb_act_d & rb_d[7];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rb_q      <= 8'h00;
            rb_left_q <= 3'd0;
            rb_act_q  <= 1'b0;
        end else begin
            rb_q      <= rb_d;
            rb_left_q <= rb_left_d;
            rb_act_q  <= rb_act_d;
        end
    end
`else
    assign cipo_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_dly_q  <= 1'b0;
            ncs_dly_q   <= 1'b1;
            flush_q     <= 3'd0;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            cipo_q      <= 1'b0;
            regs_q      <= '0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            copi_sync_q <= copi_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            ncs_dly_q   <= ncs_dly_d;
            flush_q     <= flush_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            wr_strobe_q <= wr_strobe_d;
            frame_err_q <= frame_err_d;
            cipo_q      <= cipo_d;
            regs_q      <= regs_d;
        end
    end

    assign cipo_o          = cipo_q;
    assign wr_strobe       = wr_strobe_q;
    assign frame_err       = frame_err_q;
    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];

endmodule
